ps2_scancode_rx: RTL

//  Device-to-host PS/2 receiver ahead of the keyboard matrix mapper, in the clk65 (6.5 MHz) domain.

---
 rtl/ps2_scancode_rx.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: synchronises and filters the PS/2 lines,
// deframes 11-bit frames, folds E0/F0 prefixes into flags and emits
// one-cycle scancode or error strobes for the keyboard matrix mapper.
module ps2_scancode_rx #(
   parameter int unsigned FILTER_LEN     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 6500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clkps2,
   input  logic       dataps2,
   output logic [7:0] scancode,
   output logic       extended,
   output logic       released,
   output logic       valid,
   output logic       error
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   localparam logic [3:0]  FILT_LAST = 4'(FILTER_LEN - 1);
   localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;

   logic        clk_s1;
   logic        clk_s2;
   logic        dat_s1;
   logic        dat_s2;

   logic        filt_clk;
   logic [3:0]  filt_cnt;
   logic        bit_event;

   logic [7:0]  shreg;
   logic [2:0]  bitcnt;
   logic        par_bit;
   logic [15:0] tcount;
   logic        timeout;

   logic        start_ok;
   logic        start_err;
   logic        shift_en;
   logic        cap_par;
   logic        stop_good;
   logic        stop_bad;

   logic        frame_ok;
   logic        frame_err;
   logic        pend_ext;
   logic        pend_rel;

   // Two-stage synchronisers, preset to the idle-high bus level
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= clkps2;
         clk_s2 <= clk_s1;
         dat_s1 <= dataps2;
         dat_s2 <= dat_s1;
      end
   end

   // A bit event is the cycle in which the filtered clock is about to fall
   assign bit_event = filt_clk && !clk_s2 && (filt_cnt == FILT_LAST);

   // Clock filter: accept a new level only after FILTER_LEN equal samples
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filt_clk <= 1'b1;
         filt_cnt <= '0;
      end else if (clk_s2 == filt_clk) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
         filt_clk <= clk_s2;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + 4'd1;
      end
   end

   // Abort a frame when the bus stalls mid-frame; a bit event takes priority
   assign timeout = (state != ST_IDLE) && !bit_event && (tcount == TO_LAST);

   // Mid-frame idle counter, restarted by every bit event
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tcount <= '0;
      end else if (bit_event || (state == ST_IDLE)) begin
         tcount <= '0;
      end else begin
         tcount <= tcount + 16'd1;
      end
   end

   // Frame state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and per-bit control decode
   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      start_err = 1'b0;
      shift_en  = 1'b0;
      cap_par   = 1'b0;
      stop_good = 1'b0;
      stop_bad  = 1'b0;
      if (timeout) begin
         state_nxt = ST_IDLE;
      end else if (bit_event) begin
         case (state)
            ST_IDLE: begin
               if (dat_s2) begin
                  start_err = 1'b1;
               end else begin
                  start_ok  = 1'b1;
                  state_nxt = ST_DATA;
               end
            end
            ST_DATA: begin
               shift_en = 1'b1;
               if (bitcnt == 3'd7) begin
                  state_nxt = ST_PARITY;
               end
            end
            ST_PARITY: begin
               cap_par   = 1'b1;
               state_nxt = ST_STOP;
            end
            ST_STOP: begin
               state_nxt = ST_IDLE;
               if (dat_s2 && ((^shreg) ^ par_bit)) begin
                  stop_good = 1'b1;
               end else begin
                  stop_bad = 1'b1;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Shift register, bit counter and parity capture
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg   <= '0;
         bitcnt  <= '0;
         par_bit <= 1'b0;
      end else begin
         if (start_ok) begin
            bitcnt <= '0;
         end
         if (shift_en) begin
            shreg  <= {dat_s2, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
         end
         if (cap_par) begin
            par_bit <= dat_s2;
         end
      end
   end

   // Frame outcome, registered so the output stage acts one cycle after the stop event
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_ok  <= stop_good;
         frame_err <= stop_bad | start_err | timeout;
      end
   end

   // Output stage: prefix folding, scancode strobe and error strobe.
   // shreg is still stable here: it only shifts after a new start bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scancode <= 8'h00;
         extended <= 1'b0;
         released <= 1'b0;
         valid    <= 1'b0;
         error    <= 1'b0;
         pend_ext <= 1'b0;
         pend_rel <= 1'b0;
      end else begin
         valid <= 1'b0;
         error <= 1'b0;
         if (frame_err) begin
            error    <= 1'b1;
            pend_ext <= 1'b0;
            pend_rel <= 1'b0;
         end else if (frame_ok) begin
            if (shreg == 8'hE0) begin
               pend_ext <= 1'b1;
            end else if (shreg == 8'hF0) begin
               pend_rel <= 1'b1;
            end else begin
               scancode <= shreg;
               extended <= pend_ext;
               released <= pend_rel;
               valid    <= 1'b1;
               pend_ext <= 1'b0;
               pend_rel <= 1'b0;
            end
         end
      end
   end

endmodule
